ioctl_sdram_loader: RTL and testbench
=====================================

// Module: ioctl_sdram_loader
// PURPOSE
//  Sits between data_io and the SDRAM write port of the video/ROM controller (clock_48 domain).
//  Takes the ioctl byte download stream and packs adjacent bytes into 16-bit words.
//  Buffers the words in a small FIFO and drains them to SDRAM with a toggle req/ack handshake.
//  Raises rom_loaded only once every downloaded byte has been acknowledged by the SDRAM.
// PARAMETERS
//  FIFO_DEPTH  4   word FIFO entries; power of 2, 2..16
//  AW          22  SDRAM word-address width (byte address = {word_addr, byte_sel})
//  ROM_INDEX   0   ioctl_index value accepted; any other index is ignored
// PORTS
//  clock_48     in   1   sole clock
//  reset        in   1   asynchronous, active-high
//  ioctl_downl  in   1   download in progress
//  ioctl_index  in   8   download index
//  ioctl_wr     in   1   byte strobe; level, may last more than one cycle
//  ioctl_addr   in   25  byte address
//  ioctl_dout   in   8   byte data
//  ram_addr     out  AW  word address of the current request
//  ram_din      out  16  {hi,lo} write data
//  ram_ds       out  2   byte enables; [0]=lo/even, [1]=hi/odd
//  ram_we       out  1   1 while downloading or draining
//  ram_req      out  1   toggle request
//  ram_ack      in   1   toggle acknowledge; equals ram_req when idle
//  busy         out  1   FIFO non-empty, byte pending, or request outstanding
//  rom_loaded   out  1   all data committed
//  overflow     out  1   sticky; a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: every output 0 and ram_ds=2'b00. FIFO, pending register and FSM are cleared.
//   The SDRAM side must reset its ack to 0 at the same time.
//  Accepting bytes
//   - A byte is accepted on the rising edge of ioctl_wr when ioctl_downl=1 and ioctl_index=ROM_INDEX.
//   - ioctl_wr is registered once for edge detection.
//  Packing
//   - Even byte with no byte pending: held as pending lo; nothing is pushed.
//   - Odd byte where addr = pending addr+1: push {hi,lo}, ds=11, and clear pending.
//   - Even byte while a byte is pending: push the pending byte alone (ds=01), then hold the new byte as pending.
//   - Odd byte with no matching pending byte: push it with ds=10.
//   - Any pending byte that is not merged is pushed with ds=01 as well.
//   - Single-byte words carry the byte duplicated in both halves of din.
//   - The falling edge of ioctl_downl flushes any pending byte (ds=01).
//   - A push happens 1 cycle after the accepting edge.
//  FIFO
//   - Entry is {addr[AW:1], din, ds}.
//   - Push on full: entry dropped and overflow<=1; overflow is cleared only by reset.
//   - A push and a pop in the same cycle is legal when full.
//  Drain FSM
//   - IDLE: if FIFO non-empty, load ram_addr/din/ds from the head, toggle ram_req, go to WAIT.
//     Entering WAIT takes 1 cycle after the push.
//   - WAIT: when ram_ack==ram_req, pop and go to IDLE. Requests are issued back to back,
//     with at most one outstanding.
//   - Outputs hold stable throughout WAIT.
//  Completion
//   - rom_loaded<=1 the cycle after all of the following hold together: ioctl_downl=0,
//     a download has been seen since reset, the FIFO is empty, nothing is pending, and the FSM is in IDLE.
//   - A new accepted download start (rise of ioctl_downl with a matching index) clears rom_loaded
//     and re-arms completion.
//   - ram_we = ioctl_downl | busy.
//  Address and reset
//   - Addresses above 2^(AW+1) wrap mod 2^AW words.
//   - Reset mid-transfer discards all buffered data; the host must restart the download.
// TESTING
//  1. Bytes 0x11@0, 0x22@1, ack 3 cycles later -> one req toggle: addr=0, din=0x2211, ds=11; then rom_loaded=1.
//  2. Bytes 0xAA@4, then downl falls -> req: addr=2, din=0xAAAA, ds=01; rom_loaded rises after the ack.
//  3. Bytes 0x55@7 alone -> ds=10, din=0x5555, addr=3; bytes 0x01@8, 0x02@10 -> two ds=01 words, addr 4 and 5.
//  4. Ack withheld, 2*FIFO_DEPTH+2 words streamed -> overflow=1; exactly FIFO_DEPTH+1 requests once acks resume.
//  5. Write with ioctl_index=1 -> no req toggle, rom_loaded stays 0, busy stays 0.
//  6. reset asserted in WAIT with 3 entries queued -> next cycle all outputs 0; a new download completes normally.

Source files
------------

// File: rtl/ioctl_sdram_loader.sv
// Packs the data_io byte download stream into 16-bit words, queues them in a small FIFO
// and drains them to the SDRAM write port; rom_loaded rises once every byte is committed.
module ioctl_sdram_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 22,
  parameter int ROM_INDEX  = 0
) (
  input  logic          clock_48,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_din,
  output logic [1:0]    ram_ds,
  output logic          ram_we,
  output logic          ram_req,
  input  logic          ram_ack,
  output logic          busy,
  output logic          rom_loaded,
  output logic          overflow,
  output logic          dbg_state
);

  localparam int EW = AW + 18;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  logic          wr_q, downl_q;
  logic          idx_match, accept, dl_start, dl_end;
  logic          pend_v, pend_v_nxt;
  logic [23:0]   pend_word, pend_word_nxt;
  logic [7:0]    pend_data, pend_data_nxt;
  logic          push_v, push_v_nxt;
  logic [EW-1:0] push_e, push_e_nxt;
  logic          def_v, def_v_nxt;
  logic [EW-1:0] def_e, def_e_nxt;
  logic [EW-1:0] pend_entry, odd_entry, pair_entry;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, fifo_full, push_ok, pop, issue;
  state_t        state, state_nxt;
  logic          seen_dl, all_done;

  assign idx_match = (ioctl_index == 8'(ROM_INDEX));
  assign accept    = ioctl_wr & ~wr_q & ioctl_downl & idx_match;
  assign dl_start  = ioctl_downl & ~downl_q & idx_match;
  assign dl_end    = ~ioctl_downl & downl_q;

  // FIFO entry layout: {word address, {hi,lo}, byte enables}
  assign pend_entry = {pend_word[AW-1:0], pend_data, pend_data, 2'b01};
  assign odd_entry  = {ioctl_addr[AW:1], ioctl_dout, ioctl_dout, 2'b10};
  assign pair_entry = {ioctl_addr[AW:1], ioctl_dout, pend_data, 2'b11};

  // Byte packer. An odd byte that cannot merge with the pending even byte needs two
  // pushes; the second one is parked in def_* for a cycle. Edge detection on ioctl_wr
  // guarantees no new byte is accepted in that cycle.
  always_comb begin
    push_v_nxt    = 1'b0;
    push_e_nxt    = '0;
    def_v_nxt     = 1'b0;
    def_e_nxt     = '0;
    pend_v_nxt    = pend_v;
    pend_word_nxt = pend_word;
    pend_data_nxt = pend_data;
    if (def_v) begin
      push_v_nxt = 1'b1;
      push_e_nxt = def_e;
    end else if (accept) begin
      if (!ioctl_addr[0]) begin
        push_v_nxt    = pend_v;
        push_e_nxt    = pend_entry;
        pend_v_nxt    = 1'b1;
        pend_word_nxt = ioctl_addr[24:1];
        pend_data_nxt = ioctl_dout;
      end else if (pend_v && (ioctl_addr[24:1] == pend_word)) begin
        push_v_nxt = 1'b1;
        push_e_nxt = pair_entry;
        pend_v_nxt = 1'b0;
      end else if (pend_v) begin
        push_v_nxt = 1'b1;
        push_e_nxt = pend_entry;
        def_v_nxt  = 1'b1;
        def_e_nxt  = odd_entry;
        pend_v_nxt = 1'b0;
      end else begin
        push_v_nxt = 1'b1;
        push_e_nxt = odd_entry;
      end
    end else if (dl_end && pend_v) begin
      push_v_nxt = 1'b1;
      push_e_nxt = pend_entry;
      pend_v_nxt = 1'b0;
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign push_ok    = push_v & (~fifo_full | pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clock_48) begin
    if (push_ok) mem[wr_ptr] <= push_e;
  end

  // SDRAM handshake: a request is posted by toggling ram_req with ram_addr/ram_din/ram_ds
  // valid and held; it completes when the SDRAM makes ram_ack equal ram_req again.
  // Only one request is outstanding; the FIFO head is released when it completes.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        issue     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (ram_ack == ram_req) begin
        pop       = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign all_done  = fifo_empty & ~pend_v & ~push_v & ~def_v & (state == S_IDLE);
  assign busy      = ~fifo_empty | pend_v | push_v | def_v | (state == S_WAIT);
  assign ram_we    = ioctl_downl | busy;
  assign dbg_state = (state == S_WAIT);

  always_ff @(posedge clock_48 or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      downl_q    <= 1'b0;
      pend_v     <= 1'b0;
      pend_word  <= '0;
      pend_data  <= '0;
      push_v     <= 1'b0;
      push_e     <= '0;
      def_v      <= 1'b0;
      def_e      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      state      <= S_IDLE;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_ds     <= 2'b00;
      ram_req    <= 1'b0;
      seen_dl    <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      wr_q      <= ioctl_wr;
      downl_q   <= ioctl_downl;
      pend_v    <= pend_v_nxt;
      pend_word <= pend_word_nxt;
      pend_data <= pend_data_nxt;
      push_v    <= push_v_nxt;
      push_e    <= push_e_nxt;
      def_v     <= def_v_nxt;
      def_e     <= def_e_nxt;
      state     <= state_nxt;

      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push_v && !push_ok) overflow <= 1'b1;

      if (issue) begin
        ram_addr <= head[EW-1:18];
        ram_din  <= head[17:2];
        ram_ds   <= head[1:0];
        ram_req  <= ~ram_req;
      end

      if (dl_start) begin
        seen_dl    <= 1'b1;
        rom_loaded <= 1'b0;
      end else if (!ioctl_downl && seen_dl && all_done) begin
        rom_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Bench for ioctl_sdram_loader: table vectors, hand sequences for overflow/reset/index,
// and random downloads scored against a byte-packing reference model.
module tb_ioctl_sdram_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 22;
  localparam int W     = AW + 18;

  logic          clock_48, reset;
  logic          ioctl_downl, ioctl_wr, ram_ack;
  logic [7:0]    ioctl_index, ioctl_dout;
  logic [24:0]   ioctl_addr;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [1:0]    ram_ds;
  logic          ram_we, ram_req, busy, rom_loaded, overflow, dbg_state;

  ioctl_sdram_loader #(.FIFO_DEPTH(DEPTH), .AW(AW), .ROM_INDEX(0)) dut (
    .clock_48(clock_48), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_ds(ram_ds), .ram_we(ram_we),
    .ram_req(ram_req), .ram_ack(ram_ack), .busy(busy), .rom_loaded(rom_loaded),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock_48 = 1'b0;
  always #5 clock_48 = ~clock_48;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int n_checks = 0, n_fail = 0;
  int got_base = 0;
  bit busy_seen = 0;
  bit ack_hold = 0;
  int ack_delay = 3;
  int stab_err = 0;

  typedef struct {
    int                   nb;
    logic [1:0][24:0]     a;
    logic [1:0][7:0]      d;
    int                   ne;
    logic [1:0][W-1:0]    e;
  } vec_t;
  vec_t vt[8];

  logic [24:0] ba[32];
  logic [7:0]  bd[32];

  // SDRAM responder: records each request and acks it after ack_delay cycles
  logic [W-1:0] cap;
  int wait_cnt;
  bit active;
  initial begin
    ram_ack = 1'b0;
    wait_cnt = 0;
    active = 0;
    cap = '0;
    forever begin
      @(posedge clock_48); #1;
      if (reset) begin
        ram_ack = 1'b0; wait_cnt = 0; active = 0;
      end else if (ram_req != ram_ack && !ack_hold) begin
        if (!active) begin
          cap = {ram_addr, ram_din, ram_ds};
          active = 1;
        end else if ({ram_addr, ram_din, ram_ds} != cap) begin
          stab_err++;
        end
        if (wait_cnt >= ack_delay) begin
          got_q.push_back(cap);
          ram_ack = ram_req;
          wait_cnt = 0;
          active = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_48); #1;
      busy_seen |= busy;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    tick(2);
  endtask

  task automatic end_dl();
    ioctl_downl = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hold, input int gap);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(hold);
    ioctl_wr = 1'b0;
    tick(gap);
  endtask

  task automatic wait_loaded(input string name);
    int n = 0;
    while (!rom_loaded && n < 400) begin tick(1); n++; end
    check(name, 64'(rom_loaded), 64'd1);
  endtask

  task automatic wait_got(input int target);
    int n = 0;
    while (got_q.size() < target && n < 400) begin tick(1); n++; end
  endtask

  task automatic score(input string name);
    check({name, "_count"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_base + i < got_q.size())
        check($sformatf("%s_word%0d", name, i), 64'(got_q[got_base + i]), 64'(exp_q[i]));
    got_base = got_q.size();
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] ew(input logic [AW-1:0] wa, input logic [15:0] din, input logic [1:0] ds);
    return {wa, din, ds};
  endfunction

  // reference: word = byte address / 2 (mod 2^AW); merge an odd byte onto the even
  // byte just before it, otherwise every byte goes out alone duplicated in both halves
  function automatic logic [W-1:0] mk(input logic [24:0] a, input logic [7:0] hi, input logic [7:0] lo,
                                      input logic [1:0] ds);
    logic [24:0] word = a / 2;
    return {word[AW-1:0], hi, lo, ds};
  endfunction

  task automatic model_download(input int n);
    logic [24:0] pa = '0;
    logic [7:0] pd = '0;
    bit pv = 0;
    for (int i = 0; i < n; i++) begin
      if (ba[i] % 2 == 0) begin
        if (pv) exp_q.push_back(mk(pa, pd, pd, 2'b01));
        pv = 1; pa = ba[i]; pd = bd[i];
      end else if (pv && ba[i] == pa + 25'd1) begin
        exp_q.push_back(mk(ba[i], bd[i], pd, 2'b11));
        pv = 0;
      end else begin
        if (pv) exp_q.push_back(mk(pa, pd, pd, 2'b01));
        pv = 0;
        exp_q.push_back(mk(ba[i], bd[i], bd[i], 2'b10));
      end
    end
    if (pv) exp_q.push_back(mk(pa, pd, pd, 2'b01));
  endtask

  task automatic set_vec(input int i, input int nb, input logic [24:0] a0, input logic [7:0] d0,
                         input logic [24:0] a1, input logic [7:0] d1, input int ne,
                         input logic [W-1:0] e0, input logic [W-1:0] e1);
    vt[i].nb = nb; vt[i].a[0] = a0; vt[i].d[0] = d0; vt[i].a[1] = a1; vt[i].d[1] = d1;
    vt[i].ne = ne; vt[i].e[0] = e0; vt[i].e[1] = e1;
  endtask

  initial begin
    set_vec(0, 2, 25'd0, 8'h11, 25'd1, 8'h22, 1, ew(22'd0, 16'h2211, 2'b11), '0);
    set_vec(1, 1, 25'd4, 8'hAA, 25'd0, 8'h00, 1, ew(22'd2, 16'hAAAA, 2'b01), '0);
    set_vec(2, 1, 25'd7, 8'h55, 25'd0, 8'h00, 1, ew(22'd3, 16'h5555, 2'b10), '0);
    set_vec(3, 2, 25'd8, 8'h01, 25'd10, 8'h02, 2, ew(22'd4, 16'h0101, 2'b01), ew(22'd5, 16'h0202, 2'b01));
    set_vec(4, 2, 25'd12, 8'h33, 25'd15, 8'h44, 2, ew(22'd6, 16'h3333, 2'b01), ew(22'd7, 16'h4444, 2'b10));
    set_vec(5, 2, 25'h800006, 8'h66, 25'h800007, 8'h77, 1, ew(22'd3, 16'h7766, 2'b11), '0);
    set_vec(6, 1, 25'h7FFFFF, 8'h99, 25'd0, 8'h00, 1, ew(22'h3FFFFF, 16'h9999, 2'b10), '0);
    set_vec(7, 2, 25'h21, 8'h05, 25'h20, 8'h06, 2, ew(22'h10, 16'h0505, 2'b10), ew(22'h10, 16'h0606, 2'b01));

    // reset state
    reset = 1'b1;
    ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick(3);
    check("rst_outs_held", {ram_addr, ram_din, ram_ds, ram_we, ram_req, busy, rom_loaded, overflow}, 64'd0);
    reset = 1'b0;
    tick(2);
    check("rst_outs_released", {ram_addr, ram_din, ram_ds, ram_we, ram_req, busy, rom_loaded, overflow}, 64'd0);

    // push one cycle after the accepting edge, request one cycle after the push
    start_dl(8'd0);
    ioctl_addr = 25'd9; ioctl_dout = 8'h7E; ioctl_wr = 1'b1;
    tick(1);
    check("lat_req_e0", 64'(ram_req), 64'd0);
    ioctl_wr = 1'b0;
    tick(1);
    check("lat_req_e1", 64'(ram_req), 64'd0);
    tick(1);
    check("lat_req_e2", 64'(ram_req), 64'd1);
    end_dl();
    wait_loaded("lat_loaded");
    exp_q.push_back(ew(22'd4, 16'h7E7E, 2'b10));
    score("lat");

    // table vectors
    ack_delay = 3;
    for (int i = 0; i < 8; i++) begin
      start_dl(8'd0);
      check($sformatf("tbl%0d_loaded_cleared", i), 64'(rom_loaded), 64'd0);
      check($sformatf("tbl%0d_we", i), 64'(ram_we), 64'd1);
      for (int b = 0; b < vt[i].nb; b++) send_byte(vt[i].a[b], vt[i].d[b], 1, 2);
      end_dl();
      check($sformatf("tbl%0d_loaded_early", i), 64'(rom_loaded), 64'd0);
      wait_loaded($sformatf("tbl%0d_loaded", i));
      tick(1);
      check($sformatf("tbl%0d_idle", i), {62'd0, busy, ram_we}, 64'd0);
      for (int k = 0; k < vt[i].ne; k++) exp_q.push_back(vt[i].e[k]);
      score($sformatf("tbl%0d", i));
    end

    // random downloads against the reference model
    for (int r = 0; r < 3; r++) begin
      logic [24:0] cur;
      int pick;
      ack_delay = $urandom_range(0, 3);
      cur = 25'($urandom_range(0, 4000));
      for (int i = 0; i < 16; i++) begin
        ba[i] = cur;
        bd[i] = 8'($urandom_range(0, 255));
        pick = $urandom_range(0, 9);
        if (pick < 6) cur = cur + 25'd1;
        else if (pick < 8) cur = cur + 25'($urandom_range(2, 4));
        else cur = 25'($urandom_range(0, 33554431));
      end
      start_dl(8'd0);
      check($sformatf("rnd%0d_loaded_cleared", r), 64'(rom_loaded), 64'd0);
      for (int i = 0; i < 16; i++) send_byte(ba[i], bd[i], $urandom_range(1, 3), $urandom_range(10, 12));
      end_dl();
      wait_loaded($sformatf("rnd%0d_loaded", r));
      model_download(16);
      score($sformatf("rnd%0d", r));
    end
    check("rnd_no_overflow", 64'(overflow), 64'd0);

    // overflow: acks withheld while 2*DEPTH+1 full words plus one even byte arrive
    ack_hold = 1;
    ack_delay = 1;
    start_dl(8'd0);
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      send_byte(25'(2 * i), 8'(8'h10 + 2 * i), 1, 2);
      send_byte(25'(2 * i + 1), 8'(8'h11 + 2 * i), 1, 2);
    end
    send_byte(25'(2 * (2 * DEPTH + 1)), 8'hEE, 1, 2);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_wait_state", 64'(dbg_state), 64'd1);
    ack_hold = 0;
    wait_got(got_base + DEPTH);
    tick(5);
    end_dl();
    wait_loaded("ovf_loaded");
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back(ew(AW'(i), {8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}, 2'b11));
    exp_q.push_back(ew(AW'(2 * DEPTH + 1), 16'hEEEE, 2'b01));
    score("ovf");
    check("ovf_sticky", 64'(overflow), 64'd1);

    // reset while a request is outstanding with three words queued
    ack_hold = 1;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) begin
      send_byte(25'(8'h40 + 2 * i), 8'(8'hA0 + i), 1, 2);
      send_byte(25'(8'h41 + 2 * i), 8'(8'hB0 + i), 1, 2);
    end
    tick(3);
    check("rstw_busy", {62'd0, busy, dbg_state}, 64'd3);
    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0;
    tick(1);
    check("rstw_outs", {ram_addr, ram_din, ram_ds, ram_we, ram_req, busy, rom_loaded, overflow}, 64'd0);
    reset = 1'b0;
    ack_hold = 0;
    ack_delay = 2;
    tick(2);
    got_base = got_q.size();
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 1, 2);
    send_byte(25'd1, 8'h22, 1, 2);
    end_dl();
    wait_loaded("rstw_loaded");
    exp_q.push_back(ew(22'd0, 16'h2211, 2'b11));
    score("rstw");

    // a different download index is ignored entirely
    do_reset();
    busy_seen = 0;
    start_dl(8'd1);
    send_byte(25'd2, 8'h12, 1, 3);
    send_byte(25'd3, 8'h34, 2, 3);
    end_dl();
    tick(20);
    check("idx_req", 64'(ram_req), 64'd0);
    check("idx_loaded", 64'(rom_loaded), 64'd0);
    check("idx_busy", 64'(busy_seen), 64'd0);
    score("idx");

    check("req_stable", 64'(stab_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
